// File: rtl/mmio_key_writer_pkg.sv
// Shared constants and state encoding for the CPC keyboard-matrix MMIO writer.
// Word addresses match the responder's 6-bit register map.
package mmio_key_writer_pkg;

    localparam int NUM_KEYS = 80;
    localparam int WORD_W   = 32;
    localparam int TOP_W    = 16;

    localparam logic [5:0] KEYW0 = 6'd0;
    localparam logic [5:0] KEYW1 = 6'd1;
    localparam logic [5:0] KEYW2 = 6'd2;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_CHECK = 3'd5
    } state_t;

endpackage

// File: rtl/mmio_key_writer.sv
// Turns key press/release events into verified writes of an active-low shadow
// matrix held in three 32-bit MMIO words (the top word carries 16 keys).
module mmio_key_writer
    import mmio_key_writer_pkg::*;
#(
    parameter int MAX_RETRY = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                ev_valid_i,
    output logic                ev_ready_o,
    input  logic [6:0]          ev_key_i,
    input  logic                ev_press_i,
    output logic [5:0]          addr_o,
    output logic                write_o,
    output logic                read_o,
    output logic [WORD_W-1:0]   data_o,
    input  logic [WORD_W-1:0]   data_i,
    output logic [NUM_KEYS-1:0] matrix_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t              state;
    logic [1:0]          word;
    logic                syncing;
    logic [RW-1:0]       retry;
    logic [NUM_KEYS-1:0] shadow;
    logic [WORD_W-1:0]   rdata;

    logic key_ok;
    logic target;
    logic key_bit;
    logic accept;
    logic match;

    function automatic logic [5:0] word_addr(input logic [1:0] w);
        case (w)
            2'd0:    word_addr = KEYW0;
            2'd1:    word_addr = KEYW1;
            default: word_addr = KEYW2;
        endcase
    endfunction

    // The top word only carries 16 keys; its upper half is written as zero.
    function automatic logic [WORD_W-1:0] shadow_word(input logic [NUM_KEYS-1:0] m,
                                                      input logic [1:0] w);
        case (w)
            2'd0:    shadow_word = m[31:0];
            2'd1:    shadow_word = m[63:32];
            default: shadow_word = {{(WORD_W-TOP_W){1'b0}}, m[NUM_KEYS-1:64]};
        endcase
    endfunction

    // Responder may return anything in the unused half of the top word.
    function automatic logic word_match(input logic [NUM_KEYS-1:0] m,
                                        input logic [1:0] w,
                                        input logic [WORD_W-1:0] rd);
        if (w == 2'd2)
            word_match = (rd[TOP_W-1:0] == m[NUM_KEYS-1:64]);
        else
            word_match = (rd == shadow_word(m, w));
    endfunction

    assign key_ok  = (ev_key_i < 7'(NUM_KEYS));
    assign target  = ~ev_press_i;
    assign key_bit = key_ok ? shadow[ev_key_i] : 1'b0;
    assign accept  = ev_valid_i && (state == ST_IDLE);
    assign match   = word_match(shadow, word, rdata);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= ST_SYNC;
            word    <= 2'd0;
            syncing <= 1'b1;
            retry   <= '0;
            shadow  <= '1;
            err_o   <= 1'b0;
        end else begin
            case (state)
                ST_SYNC: begin
                    word    <= 2'd0;
                    syncing <= 1'b1;
                    state   <= ST_WRITE;
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (!key_ok) begin
                            err_o <= 1'b1;
                        end else if (key_bit != target) begin
                            shadow[ev_key_i] <= target;
                            word             <= ev_key_i[6:5];
                            state            <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: state <= ST_READ;
                ST_READ:  state <= ST_WAIT;
                ST_WAIT:  state <= ST_CHECK;
                ST_CHECK: begin
                    if (match || retry >= RW'(MAX_RETRY)) begin
                        if (!match)
                            err_o <= 1'b1;
                        retry <= '0;
                        if (syncing) begin
                            if (word == 2'd2) begin
                                syncing <= 1'b0;
                                state   <= ST_IDLE;
                            end else begin
                                word  <= word + 2'd1;
                                state <= ST_WRITE;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        retry <= retry + 1'b1;
                        state <= ST_WRITE;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

    // Read data is held by the responder; take it as WAIT ends.
    always_ff @(posedge clk_i) begin
        if (state == ST_WAIT)
            rdata <= data_i;
    end

    assign write_o    = (state == ST_WRITE);
    assign read_o     = (state == ST_READ);
    assign addr_o     = word_addr(word);
    assign data_o     = shadow_word(shadow, word);
    assign ev_ready_o = (state == ST_IDLE);
    assign busy_o     = (state != ST_IDLE);
    assign matrix_o   = shadow;

endmodule
